sd_resp_capture: RTL and testbench

Receives the serial SD CMD-line response that follows a command and checks it: framing, command index and CRC7. When the response is valid, it drives the write enables and data of the SD register file (CID, CSD, OCR, RCA, STATUS). It sits between the command transmitter and the register file, and is the only block that sequences register-file updates from card responses.

---
 rtl/sd_pkg.sv | 36 +++
 rtl/sd_crc7.sv | 24 ++
 rtl/sd_resp_capture.sv | 182 ++++++++++++++++++
 tb/tb_sd_resp_capture.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD command-line response path.
// Latency: none (types and constants only).
// Backpressure: none.
package sd_pkg;

    // resp_type encodings driven by the command transmitter
    localparam logic [2:0] RESP_NONE = 3'd0;
    localparam logic [2:0] RESP_R1   = 3'd1;
    localparam logic [2:0] RESP_R2   = 3'd2;
    localparam logic [2:0] RESP_R3   = 3'd3;
    localparam logic [2:0] RESP_R6   = 3'd6;
    localparam logic [2:0] RESP_R7   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_SHIFT,
        ST_CHECK,
        ST_UPDATE
    } state_t;

    localparam int RESP_LEN_SHORT = 48;
    localparam int RESP_LEN_LONG  = 136;

    localparam logic [5:0] CMD_SEND_CSD = 6'd9;

    // R2 and R3 carry all-ones in the index field instead of the command index
    localparam logic [5:0] IDX_RESERVED = 6'h3F;

    // Any encoding outside the defined set is treated as "no response"
    function automatic logic resp_expected(input logic [2:0] t);
        return (t == RESP_R1) || (t == RESP_R2) || (t == RESP_R3) ||
               (t == RESP_R6) || (t == RESP_R7);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1, init 0, MSB first); clr has priority over en.
// Latency: crc reflects every bit fed up to and including the previous clock edge.
// Backpressure: none; a bit is consumed on every cycle en is high.
module sd_crc7 (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    // LFSR update: shift left, fold the feedback into taps x^3 and x^0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc <= 7'd0;
        end else if (clr) begin
            crc <= 7'd0;
        end else if (en) begin
            crc <= {crc[5:0], 1'b0} ^ ({7{din ^ crc[6]}} & 7'h09);
        end
    end

endmodule

// File: rtl/sd_resp_capture.sv
// Captures and checks an SD CMD-line response, then pulses register-file writes.
// Latency: done two cycles after the end bit is sampled; timeout done TIMEOUT+2 after start.
// Backpressure: none; start is ignored while busy. Define SD_RESP_CRC_EN to check CRC7.
module sd_resp_capture
    import sd_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   resp_type,
    input  logic [5:0]   cmd_index,
    input  logic         cmd_in,
    output logic         busy,
    output logic         done,
    output logic         crc_err,
    output logic         index_err,
    output logic         end_err,
    output logic         timeout_err,
    output logic         cid_en,
    output logic         csd_en,
    output logic         ocr_en,
    output logic         rca_en,
    output logic         stat_en,
    output logic [127:0] reg_data,
    output logic [31:0]  ocr_data,
    output logic [15:0]  rca_data,
    output logic [63:0]  stat_data
);

    localparam logic [7:0] TMO_CNT    = 8'(TIMEOUT);
    localparam logic [7:0] LAST_SHORT = 8'(RESP_LEN_SHORT - 1);
    localparam logic [7:0] LAST_LONG  = 8'(RESP_LEN_LONG - 1);

    state_t       state, state_n;
    logic [2:0]   rtype;
    logic [5:0]   cidx;
    logic [7:0]   cnt;      // idle-high cycles in WAIT_START, bits received in SHIFT
    // Start and transmission bits carry nothing once the start bit is seen,
    // so only the trailing 134 bits of the longest frame are kept.
    logic [133:0] sr;
    logic         accept, is_long, is_r3, idx_bad, end_bad, crc_bad, chk_ok, upd_ok;
    logic [5:0]   idx_f;
    logic [31:0]  content;

    assign accept  = (state == ST_IDLE) && start;
    assign is_long = (rtype == RESP_R2);
    assign is_r3   = (rtype == RESP_R3);
    assign idx_f   = is_long ? sr[133:128] : sr[45:40];
    assign content = sr[39:8];
    assign idx_bad = (is_long || is_r3) ? (idx_f != IDX_RESERVED) : (idx_f != cidx);
    assign end_bad = ~sr[0];
    assign chk_ok  = ~(idx_bad | end_bad | crc_bad);

`ifdef SD_RESP_CRC_EN
    logic       crc_feed;
    logic [6:0] crc_calc;

    // Feed frame bits [47:8] (short) or [127:8] (R2) into the CRC as they arrive
    always_comb begin
        crc_feed = 1'b0;
        if (state == ST_WAIT_START) begin
            crc_feed = !is_long && (cnt != TMO_CNT) && !cmd_in;
        end else if (state == ST_SHIFT) begin
            crc_feed = is_long ? ((cnt >= 8'd8) && (cnt < 8'd128)) : (cnt < 8'd40);
        end
    end

    sd_crc7 u_crc7 (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (crc_feed),
        .din   (cmd_in),
        .crc   (crc_calc)
    );

    assign crc_bad = !is_r3 && (crc_calc != sr[7:1]);
`else
    assign crc_bad = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    // Next-state logic; timeout takes priority over a start bit on the same cycle
    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE:       if (start) state_n = resp_expected(resp_type) ? ST_WAIT_START : ST_UPDATE;
            ST_WAIT_START: if (cnt == TMO_CNT) state_n = ST_UPDATE;
                           else if (!cmd_in)   state_n = ST_SHIFT;
            ST_SHIFT:      if (cnt == (is_long ? LAST_LONG : LAST_SHORT)) state_n = ST_CHECK;
            ST_CHECK:      state_n = ST_UPDATE;
            ST_UPDATE:     state_n = ST_IDLE;
            default:       state_n = ST_IDLE;
        endcase
    end

    // Command context latch, shared counter and the receive shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rtype <= RESP_NONE;
            cidx  <= 6'd0;
            cnt   <= 8'd0;
            sr    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    rtype <= resp_type;
                    cidx  <= cmd_index;
                    cnt   <= 8'd0;
                    sr    <= '0;
                end
                ST_WAIT_START: if (cnt != TMO_CNT) begin
                    if (!cmd_in) begin
                        sr  <= {sr[132:0], cmd_in};
                        cnt <= 8'd1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_SHIFT: begin
                    sr  <= {sr[132:0], cmd_in};
                    cnt <= cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Error flags: cleared on an accepted start, set by timeout or the check
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {crc_err, index_err, end_err, timeout_err} <= 4'b0000;
        end else if (accept) begin
            {crc_err, index_err, end_err, timeout_err} <= 4'b0000;
        end else if ((state == ST_WAIT_START) && (cnt == TMO_CNT)) begin
            timeout_err <= 1'b1;
        end else if (state == ST_CHECK) begin
            crc_err   <= crc_bad;
            index_err <= idx_bad;
            end_err   <= end_bad;
        end
    end

    // Data outputs are loaded on the CHECK->UPDATE edge so they are stable with the enables
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_data  <= '0;
            ocr_data  <= '0;
            rca_data  <= '0;
            stat_data <= '0;
        end else if ((state == ST_CHECK) && chk_ok) begin
            case (rtype)
                RESP_R1, RESP_R7: stat_data <= {26'd0, idx_f, content};
                RESP_R6: begin
                    rca_data  <= content[31:16];
                    stat_data <= {26'd0, idx_f, 16'd0, content[15:0]};
                end
                RESP_R3: ocr_data <= content;
                RESP_R2: reg_data <= {sr[127:1], 1'b1};
                default: ;
            endcase
        end
    end

    assign busy   = (state == ST_WAIT_START) || (state == ST_SHIFT) || (state == ST_CHECK);
    assign done   = (state == ST_UPDATE);
    assign upd_ok = done && !(crc_err | index_err | end_err | timeout_err);

    assign stat_en = upd_ok && ((rtype == RESP_R1) || (rtype == RESP_R6) || (rtype == RESP_R7));
    assign rca_en  = upd_ok && (rtype == RESP_R6);
    assign ocr_en  = upd_ok && (rtype == RESP_R3);
    assign csd_en  = upd_ok && is_long && (cidx == CMD_SEND_CSD);
    assign cid_en  = upd_ok && is_long && (cidx != CMD_SEND_CSD);

endmodule

// File: tb/tb_sd_resp_capture.sv
// Directed bench for sd_resp_capture with a queue-based scoreboard.
// Latency: checks done cycle against the frame length and idle gap.
// Backpressure: n/a.
module tb_sd_resp_capture;

    localparam int TMO = 64;

    logic         clk = 1'b0;
    logic         reset, start, cmd_in;
    logic [2:0]   resp_type;
    logic [5:0]   cmd_index;
    logic         busy, done, crc_err, index_err, end_err, timeout_err;
    logic         cid_en, csd_en, ocr_en, rca_en, stat_en;
    logic [127:0] reg_data;
    logic [31:0]  ocr_data;
    logic [15:0]  rca_data;
    logic [63:0]  stat_data;

    sd_resp_capture #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .resp_type(resp_type),
        .cmd_index(cmd_index), .cmd_in(cmd_in), .busy(busy), .done(done),
        .crc_err(crc_err), .index_err(index_err), .end_err(end_err),
        .timeout_err(timeout_err), .cid_en(cid_en), .csd_en(csd_en),
        .ocr_en(ocr_en), .rca_en(rca_en), .stat_en(stat_en),
        .reg_data(reg_data), .ocr_data(ocr_data), .rca_data(rca_data),
        .stat_data(stat_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // en = {cid,csd,ocr,rca,stat}; err = {crc,index,end,timeout}
    typedef struct {
        string        name;
        logic [4:0]   en;
        logic [3:0]   err;
        logic [63:0]  stat;
        logic [15:0]  rca;
        logic [31:0]  ocr;
        logic [127:0] regd;
        int           done_cyc;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;
    int   zreq  = 0;
    int   zseen = 0;
    bit   fin_req = 0;

    function automatic exp_t mk(input string n, input logic [4:0] en, input logic [3:0] err,
                                input logic [63:0] st, input logic [15:0] rc,
                                input logic [31:0] oc, input logic [127:0] rg);
        exp_t e;
        e.name = n; e.en = en; e.err = err; e.stat = st; e.rca = rc;
        e.ocr = oc; e.regd = rg; e.done_cyc = 0;
        return e;
    endfunction

    function automatic logic [6:0] crc7(input logic [135:0] v, input int hi, input int lo);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = hi; i >= lo; i--) begin
            fb = v[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [135:0] short_frame(input logic [5:0] idx, input logic [31:0] c,
                                                 input logic end_b);
        logic [135:0] f;
        f = {88'd0, 2'b00, idx, c, 7'd0, end_b};
        f[7:1] = crc7(f, 47, 8);
        return f;
    endfunction

    function automatic logic [135:0] long_frame(input logic [119:0] d);
        logic [135:0] f;
        f = {2'b00, 6'h3F, d, 7'd0, 1'b1};
        f[7:1] = crc7(f, 127, 8);
        return f;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
        chk({tag, "_err"}, 128'({crc_err, index_err, end_err, timeout_err}), 128'(0));
        chk({tag, "_en"}, 128'({cid_en, csd_en, ocr_en, rca_en, stat_en}), 128'(0));
        chk({tag, "_reg"}, reg_data, 128'(0));
        chk({tag, "_ocr"}, 128'(ocr_data), 128'(0));
        chk({tag, "_rca"}, 128'(rca_data), 128'(0));
        chk({tag, "_stat"}, 128'(stat_data), 128'(0));
    endtask

    // Monitor: owns all counting; pops an expectation whenever done is seen
    always @(negedge clk) begin
        exp_t e;
        if (zreq != zseen) begin
            zseen = zreq;
            check_zero($sformatf("zero%0d", zseen));
        end
        if (!reset) begin
            if (done) begin
                if (expq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
                end else begin
                    e = expq.pop_front();
                    chk({e.name, "_cyc"}, 128'(cyc), 128'(e.done_cyc));
                    chk({e.name, "_en"}, 128'({cid_en, csd_en, ocr_en, rca_en, stat_en}), 128'(e.en));
                    chk({e.name, "_err"}, 128'({crc_err, index_err, end_err, timeout_err}), 128'(e.err));
                    if (e.en[0]) chk({e.name, "_stat"}, 128'(stat_data), 128'(e.stat));
                    if (e.en[1]) chk({e.name, "_rca"}, 128'(rca_data), 128'(e.rca));
                    if (e.en[2]) chk({e.name, "_ocr"}, 128'(ocr_data), 128'(e.ocr));
                    if (e.en[3] | e.en[4]) chk({e.name, "_reg"}, reg_data, e.regd);
                end
            end else if ({cid_en, csd_en, ocr_en, rca_en, stat_en} != 5'd0) begin
                total++; bad++;
                $display("FAIL stray_enable actual=%b required=00000", {cid_en, csd_en, ocr_en, rca_en, stat_en});
            end
        end
        if (fin_req) begin
            chk("pending_expectations", 128'(expq.size()), 128'(0));
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    // Issue a start, then drive gap idle-high cycles and nbits of the frame MSB first.
    // off is the expected done cycle relative to the accepting edge.
    task automatic run(input exp_t e_in, input logic [2:0] rt, input logic [5:0] ci,
                       input logic [135:0] fr, input int len, input int nbits, input int gap,
                       input int off, input bit hold2, input bit spur, input bit push,
                       input int settle);
        exp_t e;
        e = e_in;
        @(negedge clk);
        start = 1'b1; resp_type = rt; cmd_index = ci; cmd_in = 1'b1;
        e.done_cyc = cyc + 1 + off;
        if (push) expq.push_back(e);
        @(negedge clk);
        if (hold2) @(negedge clk);
        start = 1'b0;
        for (int g = 0; g < gap; g++) begin
            cmd_in = 1'b1;
            @(negedge clk);
        end
        for (int i = 0; i < nbits; i++) begin
            cmd_in = fr[len - 1 - i];
            start  = spur && (i == 10);
            @(negedge clk);
        end
        start = 1'b0; cmd_in = 1'b1;
        repeat (settle) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [135:0] f;
        logic [119:0] d120;
        reset = 1'b1; start = 1'b0; resp_type = 3'd0; cmd_index = 6'd0; cmd_in = 1'b1;
        repeat (2) @(negedge clk);
        #1 zreq++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // R1 to CMD13 with idle gap and a start pulse mid-frame that must be ignored
        f = short_frame(6'd13, 32'h0000_0900, 1'b1);
        run(mk("r1_cmd13", 5'b00001, 4'b0000, 64'h0000_000D_0000_0900, 0, 0, 0),
            3'd1, 6'd13, f, 48, 48, 3, 3 + 48 + 1, 0, 1, 1, 4);

        // R6 to CMD3
        f = short_frame(6'd3, 32'h1234_0500, 1'b1);
        run(mk("r6_cmd3", 5'b00011, 4'b0000, 64'h0000_0003_0000_0500, 16'h1234, 0, 0),
            3'd6, 6'd3, f, 48, 48, 0, 48 + 1, 0, 0, 1, 4);

        // R3: index all-ones, CRC field all-ones, never CRC checked
        f = {88'd0, 2'b00, 6'h3F, 32'h80FF_8000, 7'h7F, 1'b1};
        run(mk("r3_ocr", 5'b00100, 4'b0000, 0, 0, 32'h80FF_8000, 0),
            3'd3, 6'd41, f, 48, 48, 1, 1 + 48 + 1, 0, 0, 1, 4);

        // R7 to CMD8
        f = short_frame(6'd8, 32'h0000_01AA, 1'b1);
        run(mk("r7_cmd8", 5'b00001, 4'b0000, 64'h0000_0008_0000_01AA, 0, 0, 0),
            3'd7, 6'd8, f, 48, 48, 2, 2 + 48 + 1, 0, 0, 1, 4);

        // R1 with content bit 8 flipped after CRC was computed
        f = short_frame(6'd13, 32'h0000_0900, 1'b1);
        f[16] = ~f[16];
`ifdef SD_RESP_CRC_EN
        run(mk("r1_badcrc", 5'b00000, 4'b1000, 0, 0, 0, 0),
            3'd1, 6'd13, f, 48, 48, 0, 48 + 1, 0, 0, 1, 4);
`else
        run(mk("r1_badcrc", 5'b00001, 4'b0000, 64'h0000_000D_0000_0800, 0, 0, 0),
            3'd1, 6'd13, f, 48, 48, 0, 48 + 1, 0, 0, 1, 4);
`endif

        // Index mismatch: card answers 13 to CMD7
        f = short_frame(6'd13, 32'h0000_0700, 1'b1);
        run(mk("r1_badidx", 5'b00000, 4'b0100, 0, 0, 0, 0),
            3'd1, 6'd7, f, 48, 48, 0, 48 + 1, 0, 0, 1, 4);

        // End bit low
        f = short_frame(6'd13, 32'h0000_0900, 1'b0);
        run(mk("r1_badend", 5'b00000, 4'b0010, 0, 0, 0, 0),
            3'd1, 6'd13, f, 48, 48, 0, 48 + 1, 0, 0, 1, 4);

        // R2 to CMD9 -> CSD, then R2 to CMD2 -> CID
        d120 = 120'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_43;
        f = long_frame(d120);
        run(mk("r2_csd", 5'b01000, 4'b0000, 0, 0, 0, {d120, f[7:1], 1'b1}),
            3'd2, 6'd9, f, 136, 136, 2, 2 + 136 + 1, 0, 0, 1, 4);
        d120 = 120'h0003_5344_5355_3136_4780_1234_5678_9A;
        f = long_frame(d120);
        run(mk("r2_cid", 5'b10000, 4'b0000, 0, 0, 0, {d120, f[7:1], 1'b1}),
            3'd2, 6'd2, f, 136, 136, 0, 136 + 1, 0, 0, 1, 4);

        // No start bit: done in the cycle after edge T+TIMEOUT+1
        run(mk("timeout", 5'b00000, 4'b0001, 0, 0, 0, 0),
            3'd1, 6'd13, '0, 48, 0, 0, TMO + 1, 0, 0, 1, TMO + 6);

        // No response type, start held into the done cycle: one done only, flags cleared
        run(mk("none", 5'b00000, 4'b0000, 0, 0, 0, 0),
            3'd0, 6'd0, '0, 48, 0, 0, 0, 1, 0, 1, 4);

        // Reset during SHIFT after bit 20, then a clean R1
        f = short_frame(6'd13, 32'h0000_0900, 1'b1);
        run(mk("cut", 5'b00000, 4'b0000, 0, 0, 0, 0),
            3'd1, 6'd13, f, 48, 21, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1 zreq++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        f = short_frame(6'd13, 32'h0000_0B00, 1'b1);
        run(mk("r1_after_rst", 5'b00001, 4'b0000, 64'h0000_000D_0000_0B00, 0, 0, 0),
            3'd1, 6'd13, f, 48, 48, 1, 1 + 48 + 1, 0, 0, 1, 4);

        #1 fin_req = 1'b1;
    end

endmodule
